// File: rtl/axi_w_buffer_sf.sv
// AXI W-channel beat buffer with cut-through or store-and-forward release.
// Optional status ports (fill level, complete bursts) under AXI_W_BUFFER_STATUS_EN.
module axi_w_buffer_sf #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned USER_WIDTH   = 6,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned STORE_FWD    = 0,
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    localparam int unsigned CNT_W       = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [STRB_WIDTH-1:0] slave_strb_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [STRB_WIDTH-1:0] master_strb_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o,
`ifdef AXI_W_BUFFER_STATUS_EN
    output logic [CNT_W-1:0]      fill_level_o,
    output logic [CNT_W-1:0]      bursts_o,
`endif
    input  logic                  master_ready_i
);

    localparam int unsigned PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int unsigned ENTRY_W = USER_WIDTH + STRB_WIDTH + DATA_WIDTH + 1;

    logic [ENTRY_W-1:0] r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_burst_cnt;

    logic               w_wr;
    logic               w_rd;
    logic               w_valid;
    logic               w_head_last;
    logic [ENTRY_W-1:0] w_head;
    logic               w_unused;

    // Handshakes; ready depends on registered occupancy only, so a full buffer
    // never accepts a beat even if the head is read in the same cycle.
    assign slave_ready_o  = (r_count != CNT_W'(BUFFER_DEPTH));
    assign w_wr           = slave_valid_i && slave_ready_o;
    assign w_rd           = w_valid && master_ready_i;
    assign master_valid_o = w_valid;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[0];
    assign {master_user_o, master_strb_o, master_data_o, master_last_o} = w_head;

    assign w_unused = ^{test_en_i, r_burst_cnt};

    // Beat storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {slave_user_i, slave_strb_i, slave_data_i, slave_last_i};
                r_wr_ptr <= (r_wr_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy and complete-burst counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count     <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_wr && !w_rd) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - CNT_W'(1);
            end
            if ((w_wr && slave_last_i) && !(w_rd && w_head_last)) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else if (!(w_wr && slave_last_i) && (w_rd && w_head_last)) begin
                r_burst_cnt <= r_burst_cnt - CNT_W'(1);
            end
        end
    end

    if (STORE_FWD != 0) begin : g_sf
        typedef enum logic {ST_HOLD = 1'b0, ST_FORCE = 1'b1} state_e;
        state_e r_state;

        // FORCE breaks the deadlock of a burst longer than the buffer
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= ST_HOLD;
            end else begin
                case (r_state)
                    ST_HOLD: begin
                        if (r_count == CNT_W'(BUFFER_DEPTH) && r_burst_cnt == '0) begin
                            r_state <= ST_FORCE;
                        end
                    end
                    ST_FORCE: begin
                        if (w_rd && w_head_last) begin
                            r_state <= ST_HOLD;
                        end
                    end
                    default: r_state <= ST_HOLD;
                endcase
            end
        end

        assign w_valid = (r_state == ST_FORCE) ? (r_count != '0) : (r_burst_cnt != '0);
    end else begin : g_ct
        assign w_valid = (r_count != '0);
    end

`ifdef AXI_W_BUFFER_STATUS_EN
    assign fill_level_o = r_count;
    assign bursts_o     = r_burst_cnt;
`endif

endmodule
